dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Responder (slave) end of the c2c_data bus. Serves LSU loads, stores and RV atomics (LR/SC, AMO*)
//  from an internal word-addressed RAM. Sits between the core's memory stage and the data store.
//  Holds the LR reservation and computes AMO results with a read-modify-write sequence.
// PARAMETERS
//  DEPTH    1024  number of XLEN-bit words; power of two
//  LATENCY  1     request-to-ack cycles for plain accesses; >=1
// PORTS
//  clk        in   1         single clock; all state updates on rising edge
//  rst_n      in   1         synchronous, active-low reset
//  data_re    in   1         read request
//  data_we    in   1         write request
//  atomic     in   1         request is atomic; amo_op is valid
//  amo_op     in   5         RV funct5 (LR=00010 SC=00011 SWAP=00001 ADD=00000 XOR=00100 OR=01000
//                            AND=01100 MIN=10000 MAX=10100 MINU=11000 MAXU=11100)
//  data_sel   in   XLEN/8    byte enables: 0xFF = double, 0x0F/0xF0 = word lane, etc.
//  data_addr  in   XLEN      byte address; word index = addr[$clog2(DEPTH)+2:3], upper bits ignored
//  data_w     in   XLEN      write data, lane-aligned
//  data_ack   out  1         one-cycle completion pulse
//  data_r     out  XLEN      aligned read/old data; valid only in the data_ack cycle
// BEHAVIOUR
//  - Reset: data_ack=0, data_r=0, FSM=IDLE, reservation invalid. RAM contents are not reset.
//  - Master holds all request inputs stable until data_ack. Request is sampled only in IDLE.
//  - FSM: IDLE -> WAIT (plain, counter=LATENCY-1) -> ACK; IDLE -> AMO_RD -> AMO_WR -> ACK; ACK -> IDLE.
//    ACK asserts data_ack for exactly one cycle. Back-to-back requests need >=1 IDLE cycle.
//    Plain access: ack LATENCY+1 cycles after the request is first seen in IDLE.
//  - Priority: atomic=1 takes the AMO path regardless of re/we. Otherwise we beats re.
//    re=we=0 with atomic=0 is ignored.
//  - Write: only bytes with data_sel set are updated. Read: data_r = full aligned word; sel is ignored.
//  - LR: read path. Sets reservation {valid, word index}. Returns word.
//  - SC: on valid && index match, write bytes under sel and return data_r=0. Otherwise no write, data_r=1.
//    Any SC clears the reservation. A plain write to the reserved index also clears it.
//  - AMO: AMO_RD latches old word. AMO_WR writes f(old_lane, data_w lane) under sel. data_r = old full word.
//  - Operand width: sel==0xFF selects 64-bit ops. Otherwise the op acts on the selected 32-bit lane;
//    MIN/MAX compare signed, MINU/MAXU compare unsigned, ADD wraps modulo 2^width.
//  - Undefined amo_op: treated as SWAP.
//  - Reset asserted mid-operation: no ack is issued. Any partial AMO write already committed stays.
// CONFIGURATION
//  DMEM_ATOMIC_EN defined:   full LR/SC/AMO support as above.
//  DMEM_ATOMIC_EN undefined: no reservation register and no ALU.
//    LR behaves as a plain read. SC never writes and returns 1.
//    Other AMOs return the old word with no write. Ack timing follows the plain-access path.
// STRUCTURE
//  - Package pipeline gains amo_op_e (funct5 encodings) and dmem_state_e; XLEN is taken from pipeline.
//  - Sub-module amo_alu: combinational (op, old, operand, is_word, lane) -> new value.
//    Present only under DMEM_ATOMIC_EN.
// TESTING
//  1 Reset, then we=1 sel=0xFF addr=0x10 w=0xDEADBEEF_01234567, then re addr=0x10
//    -> ack after LATENCY+1 cycles each; read returns the stored word.
//  2 Mem[0x10]=0 then we sel=0x0F w=0x11223344
//    -> read gives 0x00000000_11223344; upper lane untouched.
//  3 LR 0x20, then SC 0x20 w=5 -> data_r=0 and mem=5. Second SC 0x20 -> data_r=1, mem stays 5.
//  4 LR 0x20, plain write 0x20, then SC 0x20 -> data_r=1, no write.
//  5 Mem[0x30]=0xFFFFFFFF_FFFFFFFF, AMOMAX.W lane0 w=1 -> old word returned, lane0=1 (signed -1<1).
//    AMOMAXU.W on the same value -> lane0 unchanged.
//  6 Reset pulsed during AMO_RD -> no ack; next request is served normally.
//    Without DMEM_ATOMIC_EN, SC always returns 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline package: data width plus the encodings used by the data-memory responder.
//   XLEN          : datapath width in bits
//   amo_op_e      : RV atomic funct5 encodings
//   dmem_state_e  : responder FSM states
package pipeline;

  localparam int XLEN = 64;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_AMO_RD,
    S_AMO_WR,
    S_ACK
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_amo_alu.sv
// amo_alu: combinational read-modify-write function for AMO instructions.
//   op       : AMO funct5 (undefined encodings behave as SWAP)
//   old      : current memory word
//   operand  : lane-aligned write data from the master
//   is_word  : 1 = 32-bit op on one lane, 0 = full 64-bit op
//   lane     : selects upper (1) or lower (0) 32-bit lane when is_word
//   result   : full word with the new value placed in the operated lane
module amo_alu
  import pipeline::*;
(
  input  amo_op_e          op,
  input  logic [XLEN-1:0]  old,
  input  logic [XLEN-1:0]  operand,
  input  logic             is_word,
  input  logic             lane,
  output logic [XLEN-1:0]  result
);

  localparam int H = XLEN / 2;

  logic [H-1:0]    a32, b32, r32;
  logic [XLEN-1:0] r64;

  always_comb begin
    a32 = lane ? old[XLEN-1:H]     : old[H-1:0];
    b32 = lane ? operand[XLEN-1:H] : operand[H-1:0];
    case (op)
      AMO_ADD:  begin r32 = a32 + b32; r64 = old + operand; end
      AMO_XOR:  begin r32 = a32 ^ b32; r64 = old ^ operand; end
      AMO_OR:   begin r32 = a32 | b32; r64 = old | operand; end
      AMO_AND:  begin r32 = a32 & b32; r64 = old & operand; end
      AMO_MIN:  begin
        r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
        r64 = ($signed(old) < $signed(operand)) ? old : operand;
      end
      AMO_MAX:  begin
        r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
        r64 = ($signed(old) > $signed(operand)) ? old : operand;
      end
      AMO_MINU: begin
        r32 = (a32 < b32) ? a32 : b32;
        r64 = (old < operand) ? old : operand;
      end
      AMO_MAXU: begin
        r32 = (a32 > b32) ? a32 : b32;
        r64 = (old > operand) ? old : operand;
      end
      default:  begin r32 = b32; r64 = operand; end
    endcase
    if (!is_word)  result = r64;
    else if (lane) result = {r32, old[H-1:0]};
    else           result = {old[XLEN-1:H], r32};
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the c2c_data bus, backed by a word-addressed RAM.
// Serves loads, byte-masked stores and (with DMEM_ATOMIC_EN defined) LR/SC and AMOs.
// Without DMEM_ATOMIC_EN: LR is a plain read, SC returns 1 without writing, other
// AMOs return the old word without writing; all use plain-access timing.
//   clk, rst_n : clock, synchronous active-low reset
//   data_re/we : read / write request (held until data_ack)
//   atomic     : request is atomic, amo_op valid
//   amo_op     : RV funct5
//   data_sel   : byte enables
//   data_addr  : byte address, word index = addr[$clog2(DEPTH)+2:3]
//   data_w     : lane-aligned write data
//   data_ack   : one-cycle completion pulse
//   data_r     : read / old data, valid with data_ack
module dmem_responder
  import pipeline::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_re,
  input  logic              data_we,
  input  logic              atomic,
  input  logic [4:0]        amo_op,
  input  logic [XLEN/8-1:0] data_sel,
  input  logic [XLEN-1:0]   data_addr,
  input  logic [XLEN-1:0]   data_w,
  output logic              data_ack,
  output logic [XLEN-1:0]   data_r
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] word;
  amo_op_e         op;
  logic            mem_we;
  logic [XLEN-1:0] mem_wdata;
  logic            r_load;
  logic [XLEN-1:0] r_nxt;

  // Address bits outside the word index carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{data_addr[XLEN-1:AW+3], data_addr[2:0]};

  assign idx      = data_addr[AW+2:3];
  assign word     = mem[idx];
  assign op       = amo_op_e'(amo_op);
  assign data_ack = (state == S_ACK);

`ifdef DMEM_ATOMIC_EN
  logic [XLEN-1:0] old;
  logic [XLEN-1:0] alu_res;
  logic            resv_vld;
  logic [AW-1:0]   resv_idx;
  logic            resv_set, resv_clr;
  logic            resv_hit;

  assign resv_hit = resv_vld && (resv_idx == idx);

  amo_alu u_alu (
    .op      (op),
    .old     (old),
    .operand (data_w),
    .is_word (data_sel != '1),
    .lane    (data_sel[3:0] == 4'h0),
    .result  (alu_res)
  );
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_wdata = word;
    r_load    = 1'b0;
    r_nxt     = '0;
`ifdef DMEM_ATOMIC_EN
    resv_set  = 1'b0;
    resv_clr  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (atomic) begin
`ifdef DMEM_ATOMIC_EN
          state_nxt = S_AMO_RD;
`else
          state_nxt = S_WAIT;
          cnt_nxt   = CW'(LATENCY - 1);
`endif
        end else if (data_we || data_re) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CW'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_ACK;
          r_load    = 1'b1;
          if (!atomic && data_we) begin
            mem_we    = 1'b1;
            mem_wdata = data_w;
`ifdef DMEM_ATOMIC_EN
            resv_clr  = resv_hit;
`endif
          end else if (atomic && op == AMO_SC) begin
            // SC without reservation support always reports failure.
            r_nxt = {{(XLEN-1){1'b0}}, 1'b1};
          end else begin
            r_nxt = word;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_AMO_RD: state_nxt = S_AMO_WR;
      S_AMO_WR: begin
        state_nxt = S_ACK;
`ifdef DMEM_ATOMIC_EN
        r_load = 1'b1;
        case (op)
          AMO_LR: begin
            r_nxt    = old;
            resv_set = 1'b1;
          end
          AMO_SC: begin
            resv_clr = 1'b1;
            if (resv_hit) begin
              mem_we    = 1'b1;
              mem_wdata = data_w;
              r_nxt     = '0;
            end else begin
              r_nxt = {{(XLEN-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            mem_we    = 1'b1;
            mem_wdata = alu_res;
            r_nxt     = old;
          end
        endcase
`endif
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      data_r <= '0;
`ifdef DMEM_ATOMIC_EN
      old      <= '0;
      resv_vld <= 1'b0;
      resv_idx <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (r_load) data_r <= r_nxt;
`ifdef DMEM_ATOMIC_EN
      if (state == S_AMO_RD) old <= word;
      if (resv_set) begin
        resv_vld <= 1'b1;
        resv_idx <= idx;
      end else if (resv_clr) begin
        resv_vld <= 1'b0;
      end
`endif
    end
  end

  // RAM is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      for (int b = 0; b < XLEN/8; b++)
        if (data_sel[b]) mem[idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

endmodule
